// File: rtl/spi_pkg.sv
// Shared definitions for the SPI blocks: the PCM word width (also used by the
// transmit block) and the receiver FSM state encoding.
package spi_pkg;

   localparam int SPI_WORD_W = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SHIFT   = 2'd1,
      WAIT_CS = 2'd2
   } spi_rx_state_t;

endpackage

// File: rtl/spi_rx_fifo.sv
// Circular FIFO for completed receive words. Pointers carry one extra wrap bit
// so full and empty are told apart without a separate counter. The caller
// only pushes when there is room (or a pop happens in the same cycle).
// rd_data holds the most recently popped word while the FIFO is empty.
module spi_rx_fifo import spi_pkg::*; #(
   parameter int WIDTH = SPI_WORD_W,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] last_q, last_d;
   logic [AW-1:0]    wr_idx, rd_idx;

   assign wr_idx    = wr_ptr_q[AW-1:0];
   assign rd_idx    = rd_ptr_q[AW-1:0];
   assign empty_o   = (wr_ptr_q == rd_ptr_q);
   assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);
   assign rd_data_o = empty_o ? last_q : mem_q[rd_idx];

   // Next-state for storage, pointers and the last-popped word.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      last_d   = last_q;
      if (push_i) begin
         mem_d[wr_idx] = push_data_i;
         wr_ptr_d      = wr_ptr_q + 1'b1;
      end
      if (pop_i && !empty_o) begin
         last_d   = mem_q[rd_idx];
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   // FIFO state registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         last_q   <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         last_q   <= last_d;
      end
   end

endmodule

// File: rtl/spi_rx.sv
// SPI mode-0 slave receiver. Oversamples sck/sdi/cs_n in the clk domain,
// shifts MSB-first WIDTH-bit words and offers them on a valid/ready port.
// Build option SPI_RX_FIFO_EN: when defined, completed words queue in a
// FIFO_DEPTH-entry FIFO; otherwise a single holding register is used.
//
// Handshake: sample_out is a word only while sample_valid=1; the word is
// consumed on a clk edge where sample_valid && sample_ready, and
// sample_valid/sample_out update on that same edge. sample_ready while empty
// is ignored.
module spi_rx import spi_pkg::*; #(
   parameter int WIDTH       = SPI_WORD_W,
   parameter int SYNC_STAGES = 2,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             sck,
   input  logic             sdi,
   input  logic             cs_n,
   output logic [WIDTH-1:0] sample_out,
   output logic             sample_valid,
   input  logic             sample_ready,
   output logic             overrun,
   output logic             frame_err
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   // ---------------- synchronizers and edge detect ----------------
   logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
   logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
   logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
   logic                   sck_prev_q, sck_prev_d;
   logic                   sck_s, sdi_s, cs_n_s, sck_rise;

   assign sck_s    = sck_sync_q[SYNC_STAGES-1];
   assign sdi_s    = sdi_sync_q[SYNC_STAGES-1];
   assign cs_n_s   = cs_sync_q[SYNC_STAGES-1];
   assign sck_rise = sck_s && !sck_prev_q;

   // Shift each pin one stage further down its synchronizer chain.
   always_comb begin
      sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], sck};
      sdi_sync_d = {sdi_sync_q[SYNC_STAGES-2:0], sdi};
      cs_sync_d  = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
      sck_prev_d = sck_s;
   end

   // Synchronizer registers; cs_n resets to the inactive (high) level.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sck_sync_q <= '0;
         sdi_sync_q <= '0;
         cs_sync_q  <= '1;
         sck_prev_q <= 1'b0;
      end else begin
         sck_sync_q <= sck_sync_d;
         sdi_sync_q <= sdi_sync_d;
         cs_sync_q  <= cs_sync_d;
         sck_prev_q <= sck_prev_d;
      end
   end

   // ---------------- frame FSM ----------------
   spi_rx_state_t    state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic             push_q, push_d;
   logic             frame_err_q, frame_err_d;

   // Next state: cs_n release beats a simultaneous sck edge in SHIFT.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      shreg_d     = shreg_q;
      push_d      = 1'b0;
      frame_err_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (!cs_n_s) begin
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (cs_n_s) begin
               frame_err_d = (cnt_q != '0);
               cnt_d       = '0;
               state_d     = IDLE;
            end else if (sck_rise) begin
               shreg_d = {shreg_q[WIDTH-2:0], sdi_s};
               cnt_d   = cnt_q + 1'b1;
               if (cnt_q == LAST_BIT) begin
                  push_d  = 1'b1;
                  state_d = WAIT_CS;
               end
            end
         end
         WAIT_CS: begin
            if (cs_n_s) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM, counter, shift register and pulse registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         shreg_q     <= '0;
         push_q      <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shreg_q     <= shreg_d;
         push_q      <= push_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign frame_err = frame_err_q;

   // ---------------- output queue ----------------
   logic overrun_q, overrun_d;
   logic pop, accept;

`ifdef SPI_RX_FIFO_EN
   logic             fifo_full, fifo_empty;
   logic [WIDTH-1:0] fifo_rd;

   assign pop       = !fifo_empty && sample_ready;
   assign accept    = push_q && (!fifo_full || pop);
   assign overrun_d = push_q && !accept;

   spi_rx_fifo #(.WIDTH(WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk         (clk),
      .reset_n     (reset_n),
      .push_i      (accept),
      .push_data_i (shreg_q),
      .pop_i       (pop),
      .rd_data_o   (fifo_rd),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   assign sample_out   = fifo_rd;
   assign sample_valid = !fifo_empty;
`else
   logic [WIDTH-1:0] hold_q, hold_d;
   logic             hold_valid_q, hold_valid_d;

   assign pop       = hold_valid_q && sample_ready;
   assign accept    = push_q && (!hold_valid_q || pop);
   assign overrun_d = push_q && !accept;

   // Single-entry holding register; data stays put after it is consumed.
   always_comb begin
      hold_d       = hold_q;
      hold_valid_d = hold_valid_q;
      if (accept) begin
         hold_d       = shreg_q;
         hold_valid_d = 1'b1;
      end else if (pop) begin
         hold_valid_d = 1'b0;
      end
   end

   // Holding register flops.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hold_q       <= '0;
         hold_valid_q <= 1'b0;
      end else begin
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
      end
   end

   assign sample_out   = hold_q;
   assign sample_valid = hold_valid_q;
`endif

   // Overrun pulse lands in the cycle the dropped word would have appeared.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) overrun_q <= 1'b0;
      else          overrun_q <= overrun_d;
   end

   assign overrun = overrun_q;

endmodule

// File: tb/tb_spi_rx.sv
// Directed bench for spi_rx: words are shifted in at 10 MHz sck, expected
// words are queued when a frame is sent, and a monitor pops/compares on each
// valid&&ready transfer. Also honours SPI_RX_FIFO_EN for the overrun case.
module tb_spi_rx;
   import spi_pkg::*;

   localparam int W = SPI_WORD_W;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         sck = 1'b0;
   logic         sdi = 1'b0;
   logic         cs_n = 1'b1;
   logic         sample_ready = 1'b1;
   logic [W-1:0] sample_out;
   logic         sample_valid;
   logic         overrun;
   logic         frame_err;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] exp_w;
   int           n_checks = 0;
   int           n_pass = 0;
   int           ovr_seen = 0;
   int           ferr_seen = 0;
   int           valid_cycles = 0;
   int           ovr_base, ferr_base;
   logic         watch_valid = 1'b0;
   time          last_rise = 0;
   time          first_valid_t = 0;

   spi_rx #(.WIDTH(W), .SYNC_STAGES(2), .FIFO_DEPTH(4)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .sck          (sck),
      .sdi          (sdi),
      .cs_n         (cs_n),
      .sample_out   (sample_out),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .overrun      (overrun),
      .frame_err    (frame_err)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // monitor + scoreboard: sample on the falling edge
   always @(negedge clk) begin
      if (reset_n) begin
         if (overrun) ovr_seen++;
         if (frame_err) ferr_seen++;
         if (sample_valid) valid_cycles++;
         if (sample_valid && watch_valid) begin
            first_valid_t = $time;
            watch_valid = 1'b0;
         end
         if (sample_valid && sample_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_word: got %h expected none", sample_out);
            end else begin
               exp_w = exp_q.pop_front();
               check("word", {16'h0, sample_out}, {16'h0, exp_w});
            end
         end
      end
   end

   // driver: one frame of nbits sck pulses, MSB first, extra bits random
   task automatic send_bits(input logic [W-1:0] word, input int nbits);
      cs_n = 1'b0;
      #100;
      for (int i = 0; i < nbits; i++) begin
         if (i < W) sdi = word[W-1-i];
         else       sdi = 1'($urandom_range(0, 1));
         #50;
         sck = 1'b1;
         last_rise = $time;
         #50;
         sck = 1'b0;
      end
      #100;
      cs_n = 1'b1;
      #200;
   endtask

   task automatic set_ready(input logic r);
      @(posedge clk);
      #1 sample_ready = r;
      #9;
   endtask

   initial begin
      // reset values
      #20;
      check("rst_valid", {31'h0, sample_valid}, 32'h0);
      check("rst_out", {16'h0, sample_out}, 32'h0);
      check("rst_overrun", {31'h0, overrun}, 32'h0);
      check("rst_frame_err", {31'h0, frame_err}, 32'h0);
      #80;
      reset_n = 1'b1;
      #100;

      // single word: latency and one-cycle valid
      valid_cycles = 0;
      exp_q.push_back(16'hA5A5);
      watch_valid = 1'b1;
      send_bits(16'hA5A5, 16);
      check("latency_ns", 32'(first_valid_t - last_rise), 32'd40);
      check("valid_cycles", valid_cycles, 1);

      // sequence of frames
      ovr_base = ovr_seen;
      ferr_base = ferr_seen;
      exp_q.push_back(16'h5A5A); send_bits(16'h5A5A, 16);
      exp_q.push_back(16'hFFFF); send_bits(16'hFFFF, 16);
      exp_q.push_back(16'h0000); send_bits(16'h0000, 16);
      exp_q.push_back(16'h1234); send_bits(16'h1234, 16);
      check("seq_overrun", ovr_seen - ovr_base, 0);
      check("seq_frame_err", ferr_seen - ferr_base, 0);

      // partial frame then full frame
      ferr_base = ferr_seen;
      valid_cycles = 0;
      send_bits(16'hBEEF, 8);
      check("partial_frame_err", ferr_seen - ferr_base, 1);
      check("partial_no_valid", valid_cycles, 0);
      exp_q.push_back(16'hCAFE);
      send_bits(16'hCAFE, 16);

      // overrun with consumer stalled
      ovr_base = ovr_seen;
      set_ready(1'b0);
`ifdef SPI_RX_FIFO_EN
      for (int k = 1; k <= 5; k++) begin
         if (k <= 4) exp_q.push_back(W'(k));
         send_bits(W'(k), 16);
      end
`else
      exp_q.push_back(16'h0001);
      send_bits(16'h0001, 16);
      send_bits(16'h0002, 16);
`endif
      check("overrun_pulses", ovr_seen - ovr_base, 1);
      set_ready(1'b1);
      #200;

      // extra sck pulses in one frame
      exp_q.push_back(16'h8001);
      send_bits(16'h8001, 20);

      // reset mid-frame
      cs_n = 1'b0;
      #100;
      for (int i = 0; i < 5; i++) begin
         sdi = 1'b1;
         #50 sck = 1'b1;
         #50 sck = 1'b0;
      end
      reset_n = 1'b0;
      #20;
      check("midrst_out", {16'h0, sample_out}, 32'h0);
      check("midrst_valid", {31'h0, sample_valid}, 32'h0);
      check("midrst_overrun", {31'h0, overrun}, 32'h0);
      check("midrst_frame_err", {31'h0, frame_err}, 32'h0);
      cs_n = 1'b1;
      #20;
      reset_n = 1'b1;
      #200;
      exp_q.push_back(16'h00FF);
      send_bits(16'h00FF, 16);

      // drain with a bounded wait
      for (int c = 0; c < 200 && exp_q.size() != 0; c++) @(posedge clk);
      #10;
      check("queue_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
